mac_accum: RTL and testbench

Signed fixed-point multiply-accumulate back end for the EKF matrix datapath. Consumes the full-width signed products of the pipelined `mul` stage, sums a programmed number of terms (one dot-product element of a matrix product such as A·P·Aᵀ), then rounds, rescales and saturates the sum back to the working fixed-point format. The result is presented on a valid/ready output port for the matrix-update sequencer.

---
 rtl/mac_accum.sv | 171 +++++++++++++++++
 tb/tb_mac_accum.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_accum.sv
// ---------------------------------------------------------------------------
// mac_accum
//
// Signed fixed-point multiply-accumulate back end for the EKF matrix
// datapath. Sums a programmed number of full-width signed products from the
// pipelined mul stage, then rounds (half toward +inf), rescales by
// FRAC_SHIFT and saturates the sum to an OUT_WIDTH signed result. The result
// is held on a valid/ready port until the matrix-update sequencer takes it.
//
// Ports
//   clk        in   single clock, rising edge
//   n_rst      in   asynchronous active-low reset
//   start      in   begin a new accumulation (sampled only in IDLE)
//   len        in   number of products to sum (sampled with start)
//   in_valid   in   in_prod is valid this cycle
//   in_prod    in   signed two's-complement product, P_WIDTH bits
//   in_ready   out  high in ACC only; product consumed on in_valid&&in_ready
//   out_valid  out  result available (HOLD)
//   out_ready  in   consumer accepts the result
//   out_data   out  rounded, saturated signed result
//   out_sat    out  saturation occurred for out_data
//   busy       out  FSM is not IDLE
// ---------------------------------------------------------------------------
module mac_accum #(
    parameter int P_WIDTH    = 31,
    parameter int ACC_GUARD  = 4,
    parameter int FRAC_SHIFT = 14,
    parameter int OUT_WIDTH  = 16,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] len,
    input  logic                 in_valid,
    input  logic [P_WIDTH-1:0]   in_prod,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_sat,
    output logic                 busy
);

    localparam int ACC_W = P_WIDTH + ACC_GUARD;

    // Half an output LSB, added before the arithmetic shift so that the
    // truncation rounds half toward +infinity.
    localparam logic [ACC_W:0] ROUND_BIAS = {{ACC_W{1'b0}}, 1'b1} << (FRAC_SHIFT - 1);

    localparam logic [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        ROUND = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t                 state, state_next;
    logic [ACC_W-1:0]       acc, acc_next;
    logic [LEN_WIDTH-1:0]   cnt, cnt_next;
    logic [OUT_WIDTH-1:0]   data_next;
    logic                   sat_next;

    logic [ACC_W-1:0]       prod_ext;
    logic [ACC_W:0]         acc_wide;
    logic signed [ACC_W:0]  acc_shift;
    logic [ACC_W-OUT_WIDTH+1:0] upper;
    logic                   fits;
    logic                   pos_sat;
    logic                   neg_sat;

    // Sign-extend the product into the guard bits of the accumulator.
    assign prod_ext = {{ACC_GUARD{in_prod[P_WIDTH-1]}}, in_prod};

    // Rounding path: one extra MSB on the biased sum keeps the bias addition
    // from wrapping when the accumulator sits near its positive limit. The
    // result fits the output format only when every bit from the output sign
    // bit upwards agrees.
    assign acc_wide  = {acc[ACC_W-1], acc} + ROUND_BIAS;
    assign acc_shift = $signed(acc_wide) >>> FRAC_SHIFT;
    assign upper     = acc_shift[ACC_W:OUT_WIDTH-1];
    assign fits      = (&upper) | ~(|upper);
    assign pos_sat   = ~fits & ~acc_shift[ACC_W];
    assign neg_sat   = ~fits &  acc_shift[ACC_W];

    // Handshake flags are pure decodes of the registered state.
    assign in_ready  = (state == ACC);
    assign out_valid = (state == HOLD);
    assign busy      = (state != IDLE);

    // State and datapath registers; reset discards any partial sum.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            acc      <= '0;
            cnt      <= '0;
            out_data <= '0;
            out_sat  <= 1'b0;
        end else begin
            state    <= state_next;
            acc      <= acc_next;
            cnt      <= cnt_next;
            out_data <= data_next;
            out_sat  <= sat_next;
        end
    end

    // Next-state and datapath update. Anything not named in a branch holds,
    // so idle ACC cycles and a stalled HOLD keep all values stable.
    always_comb begin
        state_next = state;
        acc_next   = acc;
        cnt_next   = cnt;
        data_next  = out_data;
        sat_next   = out_sat;

        case (state)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        acc_next   = '0;
                        cnt_next   = len;
                        state_next = ACC;
                    end else begin
                        data_next  = '0;
                        sat_next   = 1'b0;
                        state_next = HOLD;
                    end
                end
            end

            ACC: begin
                if (in_valid) begin
                    acc_next = acc + prod_ext;
                    cnt_next = cnt - 1'b1;
                    if (cnt == {{(LEN_WIDTH-1){1'b0}}, 1'b1}) begin
                        state_next = ROUND;
                    end
                end
            end

            ROUND: begin
                if (pos_sat) begin
                    data_next = OUT_MAX;
                    sat_next  = 1'b1;
                end else if (neg_sat) begin
                    data_next = OUT_MIN;
                    sat_next  = 1'b1;
                end else begin
                    data_next = acc_shift[OUT_WIDTH-1:0];
                    sat_next  = 1'b0;
                end
                state_next = HOLD;
            end

            HOLD: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mac_accum.sv
// ---------------------------------------------------------------------------
// tb_mac_accum
//
// Self-checking bench for mac_accum. A table of vectors (term count,
// products, idle gaps before each product, expected result) is applied in a
// loop; the expected result is queued when the run is started and popped
// when out_valid appears. Hand-written sequences cover HOLD back-pressure,
// start coinciding with the hand-off, and reset in the middle of ACC.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_mac_accum;

    localparam int P_WIDTH    = 31;
    localparam int ACC_GUARD  = 4;
    localparam int FRAC_SHIFT = 14;
    localparam int OUT_WIDTH  = 16;
    localparam int LEN_WIDTH  = 4;
    localparam int NVEC       = 13;

    typedef struct packed {
        logic [3:0]       len;
        logic [3:0][30:0] prod;
        logic [3:0][1:0]  gap;
        logic [15:0]      exp_data;
        logic             exp_sat;
    } vec_t;

    logic                 clk = 1'b0;
    logic                 n_rst;
    logic                 start;
    logic [LEN_WIDTH-1:0] len;
    logic                 in_valid;
    logic [P_WIDTH-1:0]   in_prod;
    logic                 in_ready;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] out_data;
    logic                 out_sat;
    logic                 busy;

    int          checks   = 0;
    int          failures = 0;
    logic [16:0] exp_q[$];
    vec_t        vecs [NVEC];

    mac_accum #(
        .P_WIDTH   (P_WIDTH),
        .ACC_GUARD (ACC_GUARD),
        .FRAC_SHIFT(FRAC_SHIFT),
        .OUT_WIDTH (OUT_WIDTH),
        .LEN_WIDTH (LEN_WIDTH)
    ) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .start    (start),
        .len      (len),
        .in_valid (in_valid),
        .in_prod  (in_prod),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_sat  (out_sat),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Hard stop in case a sequence wedges despite the bounded waits.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_val(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, required);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] l,
                                input logic [30:0] p0, input logic [30:0] p1,
                                input logic [30:0] p2, input logic [30:0] p3,
                                input logic [1:0] g0, input logic [1:0] g1,
                                input logic [1:0] g2,
                                input logic [15:0] d, input logic s);
        vec_t v;
        v.len      = l;
        v.prod[0]  = p0;
        v.prod[1]  = p1;
        v.prod[2]  = p2;
        v.prod[3]  = p3;
        v.gap[0]   = g0;
        v.gap[1]   = g1;
        v.gap[2]   = g2;
        v.gap[3]   = 2'd0;
        v.exp_data = d;
        v.exp_sat  = s;
        return v;
    endfunction

    // Starts a run, feeds its products with the requested gaps and leaves the
    // DUT in HOLD. Junk products are offered in IDLE and ROUND, where they
    // must be dropped.
    task automatic apply_stimulus(input vec_t v);
        exp_q.push_back({v.exp_sat, v.exp_data});
        start    = 1'b1;
        len      = v.len;
        in_valid = 1'b1;
        in_prod  = 31'h2AAA_AAAA;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        if (v.len != 4'd0) begin
            check_val("in_ready_in_acc", {31'd0, in_ready}, 32'd1);
            check_val("busy_in_acc", {31'd0, busy}, 32'd1);
            for (int i = 0; i < int'(v.len); i++) begin
                for (int g = 0; g < int'(v.gap[i]); g++) begin
                    in_valid = 1'b0;
                    in_prod  = 31'h1555_5555;
                    @(negedge clk);
                end
                in_valid = 1'b1;
                in_prod  = v.prod[i];
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_prod  = 31'h3333_3333;
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    // Waits (bounded) for out_valid, checks it arrived without delay, then
    // pops the expected result and compares it.
    task automatic check_output(input string name);
        logic [16:0] exp;
        int n = 0;
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check_val({name, "_out_valid"}, {31'd0, out_valid}, 32'd1);
        check_val({name, "_latency"}, n, 32'd0);
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s_queue: got empty, required an entry", name);
        end else begin
            exp = exp_q.pop_front();
            check_val({name, "_data"}, {16'd0, out_data}, {16'd0, exp[15:0]});
            check_val({name, "_sat"}, {31'd0, out_sat}, {31'd0, exp[16]});
        end
    endtask

    task automatic handoff(input string name);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_val({name, "_busy_after"}, {31'd0, busy}, 32'd0);
        check_val({name, "_valid_after"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        n_rst     = 1'b0;
        start     = 1'b0;
        len       = '0;
        in_valid  = 1'b0;
        in_prod   = '0;
        out_ready = 1'b0;

        vecs[0]  = mk(4'd1, 31'h1000_0000, 31'h0, 31'h0, 31'h0, 0, 0, 0, 16'h4000, 1'b0);
        vecs[1]  = mk(4'd3, 31'h1000_0000, 31'h7800_0000, 31'h0400_0000, 31'h0, 0, 2, 1, 16'h3000, 1'b0);
        vecs[2]  = mk(4'd1, 31'h0000_2000, 31'h0, 31'h0, 31'h0, 0, 0, 0, 16'h0001, 1'b0);
        vecs[3]  = mk(4'd1, 31'h7FFF_E000, 31'h0, 31'h0, 31'h0, 0, 0, 0, 16'h0000, 1'b0);
        vecs[4]  = mk(4'd1, 31'h7FFF_DFFF, 31'h0, 31'h0, 31'h0, 0, 0, 0, 16'hFFFF, 1'b0);
        vecs[5]  = mk(4'd4, 31'h3FFF_FFFF, 31'h3FFF_FFFF, 31'h3FFF_FFFF, 31'h3FFF_FFFF, 0, 0, 0, 16'h7FFF, 1'b1);
        vecs[6]  = mk(4'd4, 31'h4000_0001, 31'h4000_0001, 31'h4000_0001, 31'h4000_0001, 0, 1, 0, 16'h8000, 1'b1);
        vecs[7]  = mk(4'd0, 31'h0, 31'h0, 31'h0, 31'h0, 0, 0, 0, 16'h0000, 1'b0);
        vecs[8]  = mk(4'd1, 31'h1FFF_DFFF, 31'h0, 31'h0, 31'h0, 0, 0, 0, 16'h7FFF, 1'b0);
        vecs[9]  = mk(4'd1, 31'h1FFF_E000, 31'h0, 31'h0, 31'h0, 0, 0, 0, 16'h7FFF, 1'b1);
        vecs[10] = mk(4'd1, 31'h6000_0000, 31'h0, 31'h0, 31'h0, 0, 0, 0, 16'h8000, 1'b0);
        vecs[11] = mk(4'd1, 31'h5FFF_DFFF, 31'h0, 31'h0, 31'h0, 0, 0, 0, 16'h8000, 1'b1);
        vecs[12] = mk(4'd2, 31'h0000_4000, 31'h0000_4000, 31'h0, 31'h0, 1, 0, 0, 16'h0002, 1'b0);

        @(negedge clk);
        @(negedge clk);
        check_val("reset_busy", {31'd0, busy}, 32'd0);
        check_val("reset_in_ready", {31'd0, in_ready}, 32'd0);
        check_val("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("reset_out_data", {16'd0, out_data}, 32'd0);
        check_val("reset_out_sat", {31'd0, out_sat}, 32'd0);
        n_rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NVEC; i++) begin
            apply_stimulus(vecs[i]);
            check_output($sformatf("vec%0d", i));
            handoff($sformatf("vec%0d", i));
        end

        // HOLD back-pressure: result stays put, nothing is accepted, a start
        // arriving together with out_ready is ignored.
        apply_stimulus(vecs[0]);
        check_output("bp");
        for (int c = 0; c < 5; c++) begin
            start    = c[0];
            len      = 4'd2;
            in_valid = 1'b1;
            in_prod  = 31'h0123_4567;
            @(negedge clk);
            check_val("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check_val("bp_out_data", {16'd0, out_data}, 32'h4000);
            check_val("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        start     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        out_ready = 1'b0;
        check_val("bp_busy_after", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check_val("bp_start_ignored", {31'd0, busy}, 32'd0);

        // Reset in the middle of a five-term run discards the partial sum.
        start    = 1'b1;
        len      = 4'd5;
        @(negedge clk);
        start    = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_prod  = 31'h0800_0000;
            @(negedge clk);
        end
        in_valid = 1'b0;
        #2;
        n_rst = 1'b0;
        #1;
        check_val("midrst_busy", {31'd0, busy}, 32'd0);
        check_val("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        check_val("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("midrst_out_data", {16'd0, out_data}, 32'd0);
        check_val("midrst_out_sat", {31'd0, out_sat}, 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        apply_stimulus(vecs[0]);
        check_output("post_rst");
        handoff("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
